lfsr: RTL and testbench

LFSR -- requirements
Module: lfsr

---
 rtl/lfsr.sv | 72 +++++++
 tb/tb_lfsr.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/lfsr.sv
// ----------------------------------------------------------------------------
// lfsr -- Fibonacci-form linear feedback shift register, shifting left.
//
// Each rising clk edge with reset low moves the state one step:
//   next = {data[WIDTH-2:0], fb}
// fb is the XOR of every state bit selected by TAPS. With the default
// parameters this gives the maximal-length 255-state sequence starting at 8'h8A.
//
// Ports
//   clk   : input,  single clock; all state changes happen on its rising edge
//   reset : input,  synchronous active-high; loads SEED and overrides shifting
//   data  : output, WIDTH bits, current state taken straight from the register
//
// Parameters
//   WIDTH : register width (8 is the supported value)
//   SEED  : value loaded by reset and by the lock-up guard (must be nonzero)
//   TAPS  : feedback tap mask (bit i set => state bit i feeds the XOR)
// ----------------------------------------------------------------------------
module lfsr #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = 8'h8A,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] state_reg;
  logic [WIDTH-1:0] state_next;
  logic             fb;

  // Running XOR across the tapped bits. Element i holds the parity of all
  // selected bits at positions 0..i, so the last element is the feedback bit.
  logic [WIDTH-1:0] tap_chain;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tap
      if (gi == 0) begin : g_first
        assign tap_chain[gi] = state_reg[gi] & TAPS[gi];
      end else begin : g_rest
        assign tap_chain[gi] = tap_chain[gi-1] ^ (state_reg[gi] & TAPS[gi]);
      end
    end
  endgenerate

  assign fb = tap_chain[WIDTH-1];

  // All-zero is the single state the XOR feedback can never leave. If the
  // register ever reaches it (X resolution, a force), reload SEED rather than
  // shifting. From any nonzero state the shift produces a nonzero successor,
  // so this path never fires in normal operation.
  always_comb begin
    state_next = {state_reg[WIDTH-2:0], fb};
    if (state_reg == '0) begin
      state_next = SEED;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= SEED;
    end else begin
      state_reg <= state_next;
    end
  end

  // The output is the register itself, so a new state is visible right after
  // the edge that produces it.
  assign data = state_reg;

endmodule

// File: tb/tb_lfsr.sv
// ----------------------------------------------------------------------------
// tb_lfsr -- self-checking bench for lfsr with the default parameters.
// The reference is the full 255-entry cycle, built once from the tap rule.
// After that, the expected state is simply a position in the cycle: reset
// returns to position 0, and every other edge advances the position modulo 255.
// ----------------------------------------------------------------------------
module tb_lfsr;

  localparam logic [7:0] SEED = 8'h8A;
  localparam logic [7:0] TAPS = 8'hB8;

  logic       clk;
  logic       reset;
  logic [7:0] data;

  int checks   = 0;
  int failures = 0;

  logic [7:0] order [255];

  lfsr #(.WIDTH(8), .SEED(SEED), .TAPS(TAPS)) dut (
    .clk   (clk),
    .reset (reset),
    .data  (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] exp;
    string      name;
  } vec_t;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end else begin
      $display("ok   %s: data=%02h", name, act);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: value=%0d", name, act);
    end
  endtask

  // Drive reset away from the active edge, then sample just after the edge.
  task automatic step(input logic r);
    @(negedge clk);
    reset = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t       vecs [6];
    logic [7:0] s;
    int         pos;
    int         first_return;
    int         distinct;
    int         zero_seen;
    bit         seen [256];

    reset = 1'b1;

    // Reference cycle: next value = shift left, shifting in the parity of the tapped bits.
    s = SEED;
    for (int i = 0; i < 255; i++) begin
      order[i] = s;
      s = {s[6:0], 1'($countones(s & TAPS) % 2)};
    end

    // Reset held for two edges, then the first four successors.
    vecs[0] = '{1'b1, 8'h8A, "reset_edge1"};
    vecs[1] = '{1'b1, 8'h8A, "reset_edge2"};
    vecs[2] = '{1'b0, 8'h14, "step1"};
    vecs[3] = '{1'b0, 8'h29, "step2"};
    vecs[4] = '{1'b0, 8'h52, "step3"};
    vecs[5] = '{1'b0, 8'hA5, "step4"};
    for (int i = 0; i < 6; i++) begin
      step(vecs[i].rst);
      check(vecs[i].name, data, vecs[i].exp);
    end

    // Full period: returns to SEED exactly at step 255, visits each nonzero value once.
    step(1'b1);
    check("period_start", data, SEED);
    first_return = 0;
    distinct     = 0;
    zero_seen    = 0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int k = 1; k <= 255; k++) begin
      step(1'b0);
      check($sformatf("period_step%0d", k), data, order[k % 255]);
      if (data == 8'h00) zero_seen++;
      if (!seen[data]) begin
        seen[data] = 1'b1;
        distinct++;
      end
      if (data == SEED && first_return == 0) first_return = k;
    end
    check_int("period_first_return", first_return, 255);
    check_int("period_distinct", distinct, 255);
    check_int("period_zero_seen", zero_seen, 0);

    // Long run of 120 steps after reset.
    step(1'b1);
    for (int k = 1; k <= 120; k++) begin
      step(1'b0);
      check($sformatf("long_step%0d", k), data, order[k]);
    end

    // 20 steps, reset held for 10 edges, then release.
    for (int k = 0; k < 20; k++) step(1'b0);
    check("pre_mid_reset", data, order[140 % 255]);
    for (int k = 0; k < 10; k++) begin
      step(1'b1);
      check($sformatf("mid_reset_edge%0d", k), data, 8'h8A);
    end
    step(1'b0);
    check("mid_reset_release", data, 8'h14);

    // A reset pulse that never spans a rising edge has no effect.
    @(negedge clk);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("short_reset_pulse", data, order[2]);

    // Lock-up guard: force the state to zero, release, one clock without reset.
    @(negedge clk);
    force dut.state_reg = 8'h00;
    #1;
    release dut.state_reg;
    @(posedge clk);
    #1;
    check("lockup_reload", data, 8'h8A);
    step(1'b0);
    check("lockup_then_step", data, 8'h14);

    // Randomised reset pattern checked against the position-in-cycle model.
    step(1'b1);
    pos = 0;
    for (int k = 0; k < 400; k++) begin
      logic r;
      r = ($urandom_range(0, 9) == 0);
      step(r);
      if (r) pos = 0;
      else   pos = (pos + 1) % 255;
      check($sformatf("random_cycle%0d_rst%0d", k, r), data, order[pos]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
